// File: rtl/duck_round_sequencer_if.sv
// Round sequencer handshake bundle: game_logic status in, duck control and HUD out.
// master drives game_enable/hunt_start/duck_killed/ammo; slave is the sequencer.
interface duck_round_sequencer_if;
  logic       game_enable;
  logic       hunt_start;
  logic       duck_killed;
  logic [2:0] bullets_in_mag;
  logic [6:0] bullets_left;
  logic       duck_spawn;
  logic       duck_fly_away;
  logic [3:0] duck_speed;
  logic [3:0] round_num;
  logic [3:0] duck_index;
  logic [3:0] ducks_hit;
  logic [3:0] ducks_missed;
  logic       round_done;
  logic       game_over;
  logic       game_won;
  logic       perfect_bonus;

  modport master (
    output game_enable, hunt_start, duck_killed,
    output bullets_in_mag, bullets_left,
    input  duck_spawn, duck_fly_away, duck_speed,
    input  round_num, duck_index, ducks_hit, ducks_missed,
    input  round_done, game_over, game_won, perfect_bonus
  );

  modport slave (
    input  game_enable, hunt_start, duck_killed,
    input  bullets_in_mag, bullets_left,
    output duck_spawn, duck_fly_away, duck_speed,
    output round_num, duck_index, ducks_hit, ducks_missed,
    output round_done, game_over, game_won, perfect_bonus
  );
endinterface

// File: rtl/duck_round_sequencer.sv
// Round/wave scheduler: paces duck spawns, times escapes, tallies rounds, declares win/lose.
// Ports: clk, rst (sync, active-high), bus (duck_round_sequencer_if.slave).
// Option: define DUCK_ROUND_PERFECT_BONUS_EN for the perfect-round bonus (+2 speed, pulse).
module duck_round_sequencer #(
  parameter int ESCAPE_CYCLES   = 325_000_000,
  parameter int RESPAWN_CYCLES  = 65_000_000,
  parameter int DUCKS_PER_ROUND = 10,
  parameter int PASS_HITS       = 6,
  parameter int MAX_ROUND       = 9,
  parameter int SPEED_BASE      = 1
) (
  input logic clk,
  input logic rst,
  duck_round_sequencer_if.slave bus
);

  localparam int EW = $clog2(ESCAPE_CYCLES + 1);
  localparam int GW = $clog2(RESPAWN_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SPAWN,
    FLYING,
    RESOLVE,
    ROUND_END,
    GAME_OVER
  } state_t;

  state_t state_q, state_d;

  logic [EW-1:0] esc_q, esc_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          killed_q;
  logic [3:0]    round_q, round_d;
  logic [3:0]    speed_q, speed_d;
  logic [3:0]    index_q, index_d;
  logic [3:0]    hit_q, hit_d;
  logic [3:0]    miss_q, miss_d;
  logic          spawn_q, spawn_d;
  logic          fly_q, fly_d;
  logic          done_q, done_d;
  logic          over_q, over_d;
  logic          won_q, won_d;
  logic          bonus_q, bonus_d;

  logic       kill;
  logic       ammo_out;
  logic       perfect;
  logic [3:0] index_inc;
  logic [3:0] speed_p1;
  logic [3:0] speed_p2;

  assign kill     = bus.duck_killed & ~killed_q;
  assign ammo_out = (bus.bullets_in_mag == 3'd0)
                 && (bus.bullets_left == 7'd0);
  assign index_inc = index_q + 4'd1;
  assign speed_p1  = (speed_q == 4'hf) ? 4'hf : speed_q + 4'd1;
  assign speed_p2  = (speed_q >= 4'he) ? 4'hf : speed_q + 4'd2;

`ifdef DUCK_ROUND_PERFECT_BONUS_EN
  assign perfect = (hit_q == 4'(DUCKS_PER_ROUND));
`else
  assign perfect = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    esc_d   = esc_q;
    gap_d   = gap_q;
    round_d = round_q;
    speed_d = speed_q;
    index_d = index_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    over_d  = over_q;
    won_d   = won_q;
    spawn_d = 1'b0;
    fly_d   = 1'b0;
    done_d  = 1'b0;
    bonus_d = 1'b0;

    if (!bus.game_enable) begin
      state_d = IDLE;
      esc_d   = '0;
      gap_d   = '0;
      round_d = '0;
      speed_d = '0;
      index_d = '0;
      hit_d   = '0;
      miss_d  = '0;
      over_d  = 1'b0;
      won_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_SPAWN;
          round_d = 4'd1;
          speed_d = 4'(SPEED_BASE);
          gap_d   = '0;
          index_d = '0;
          hit_d   = '0;
          miss_d  = '0;
        end
        WAIT_SPAWN: begin
          if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
          end else if (bus.hunt_start) begin
            state_d = FLYING;
            spawn_d = 1'b1;
            esc_d   = EW'(ESCAPE_CYCLES - 1);
          end
        end
        FLYING: begin
          // a kill landing on the last flight cycle still counts
          if (kill) begin
            state_d = RESOLVE;
            hit_d   = hit_q + 4'd1;
          end else if (esc_q == '0 || ammo_out) begin
            state_d = RESOLVE;
            miss_d  = miss_q + 4'd1;
            fly_d   = 1'b1;
          end else begin
            esc_d = esc_q - 1'b1;
          end
        end
        RESOLVE: begin
          index_d = index_inc;
          if (index_inc == 4'(DUCKS_PER_ROUND)) begin
            state_d = ROUND_END;
          end else begin
            state_d = WAIT_SPAWN;
            gap_d   = GW'(RESPAWN_CYCLES - 1);
          end
        end
        ROUND_END: begin
          if (hit_q < 4'(PASS_HITS)) begin
            state_d = GAME_OVER;
            over_d  = 1'b1;
            won_d   = 1'b0;
          end else begin
            bonus_d = perfect;
            if (round_q == 4'(MAX_ROUND)) begin
              state_d = GAME_OVER;
              over_d  = 1'b1;
              won_d   = 1'b1;
            end else begin
              state_d = WAIT_SPAWN;
              done_d  = 1'b1;
              round_d = round_q + 4'd1;
              speed_d = perfect ? speed_p2 : speed_p1;
              index_d = '0;
              hit_d   = '0;
              miss_d  = '0;
              gap_d   = GW'(RESPAWN_CYCLES - 1);
            end
          end
        end
        GAME_OVER: begin
          state_d = GAME_OVER;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      esc_q    <= '0;
      gap_q    <= '0;
      killed_q <= 1'b0;
      round_q  <= '0;
      speed_q  <= '0;
      index_q  <= '0;
      hit_q    <= '0;
      miss_q   <= '0;
      spawn_q  <= 1'b0;
      fly_q    <= 1'b0;
      done_q   <= 1'b0;
      over_q   <= 1'b0;
      won_q    <= 1'b0;
      bonus_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      esc_q    <= esc_d;
      gap_q    <= gap_d;
      killed_q <= bus.duck_killed;
      round_q  <= round_d;
      speed_q  <= speed_d;
      index_q  <= index_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      spawn_q  <= spawn_d;
      fly_q    <= fly_d;
      done_q   <= done_d;
      over_q   <= over_d;
      won_q    <= won_d;
      bonus_q  <= bonus_d;
    end
  end

  assign bus.duck_spawn    = spawn_q;
  assign bus.duck_fly_away = fly_q;
  assign bus.duck_speed    = speed_q;
  assign bus.round_num     = round_q;
  assign bus.duck_index    = index_q;
  assign bus.ducks_hit     = hit_q;
  assign bus.ducks_missed  = miss_q;
  assign bus.round_done    = done_q;
  assign bus.game_over     = over_q;
  assign bus.game_won      = won_q;
  assign bus.perfect_bonus = bonus_q;

endmodule
